// File: rtl/hmem_pkg.sv
// Shared constants and types for the hart memory responder.
// Line width comes from `HMEM_LINE (bits). It defaults to a 64-byte line when the build does not set it.
// No backpressure: this file holds only type and constant definitions.
`ifndef HMEM_LINE
`define HMEM_LINE 512
`endif

package hmem_pkg;

  localparam int LINE_W     = `HMEM_LINE;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    RD_HOLD
  } rd_state_t;

endpackage

// File: rtl/hmem_responder_array.sv
// Line-wide storage with one write port and an asynchronous (combinational) read port.
// Latency: a write lands at the clock edge; the read follows the address in the same cycle.
// No backpressure. Contents are deliberately never reset.
module hmem_array #(
  parameter int LINES = 1024,
  parameter int W     = 512,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [LINES];

  // Single write port; the array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/hmem_responder.sv
// Hart memory responder: line read/write, atomic bus-lock grant, optional invalidate (HMEM_INV_EN).
// Latency: h_dv pulses RD_LAT cycles after h_rd is accepted; h_amo_ack rises AMO_LAT cycles after h_amo_req.
// Backpressure: none. The hart holds h_rd until h_dv. Writes are accepted every cycle in any read state.
module hmem_responder
  import hmem_pkg::*;
#(
  parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
  parameter int          MEM_LINES = 1024,
  parameter int          RD_LAT    = 40,
  parameter int          AMO_LAT   = 8
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic [63:0]       h_addr,
  input  logic              h_rd,
  output logic [LINE_W-1:0] h_data_in,
  output logic              h_dv,
  input  logic              h_wr,
  input  logic [LINE_W-1:0] h_data_out,
  output logic [63:0]       h_inv_addr,
  output logic              h_inv,
  input  logic              h_amo_req,
  output logic              h_amo_ack
);

  localparam int          IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_LINES) * 64'(LINE_BYTES);

  rd_state_t         state;
  logic [7:0]        rd_cnt;
  logic [7:0]        amo_cnt;
  logic [63:0]       off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic [LINE_W-1:0] line_rd;
  logic [LINE_W-1:0] rd_line;

  // The comparison on the full offset also rejects addresses that wrapped below MEM_BASE.
  assign off      = h_addr - MEM_BASE;
  assign in_range = (h_addr >= MEM_BASE) && (off < MEM_BYTES);
  assign idx      = off[LINE_SHIFT +: IDX_W];
  assign wr_en    = h_wr & in_range;

  hmem_array #(
    .LINES (MEM_LINES),
    .W     (LINE_W),
    .AW    (IDX_W)
  ) u_array (
    .clk   (h_clk),
    .we    (wr_en),
    .addr  (idx),
    .wdata (h_data_out),
    .rdata (line_rd)
  );

  // A write in the response cycle is forwarded so that the read returns the new data.
  assign rd_line   = in_range ? (h_wr ? h_data_out : line_rd) : '0;
  assign h_dv      = (state == RD_RESP);
  assign h_data_in = h_dv ? rd_line : '0;

  // Read FSM: latency count, one response cycle, then wait for the hart to drop h_rd.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (h_rd) begin
            state  <= RD_WAIT;
            rd_cnt <= 8'(RD_LAT - 1);
          end
        end
        RD_WAIT: begin
          if (!h_rd) begin
            state  <= IDLE;
            rd_cnt <= '0;
          end else if (rd_cnt == 8'd0) begin
            state <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt - 8'd1;
          end
        end
        RD_RESP: state <= RD_HOLD;
        RD_HOLD: begin
          if (!h_rd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Atomic lock grant: count while the request is held, and clear as soon as it drops.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      amo_cnt   <= '0;
      h_amo_ack <= 1'b0;
    end else if (!h_amo_req) begin
      amo_cnt   <= '0;
      h_amo_ack <= 1'b0;
    end else if (!h_amo_ack) begin
      if (amo_cnt == 8'(AMO_LAT - 1)) h_amo_ack <= 1'b1;
      else                            amo_cnt   <= amo_cnt + 8'd1;
    end
  end

`ifdef HMEM_INV_EN
  // Invalidate pulse for each in-range write, with the line-aligned address, in the following cycle.
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      h_inv      <= 1'b0;
      h_inv_addr <= '0;
    end else begin
      h_inv <= wr_en;
      if (wr_en) h_inv_addr <= {h_addr[63:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
    end
  end
`else
  assign h_inv      = 1'b0;
  assign h_inv_addr = '0;
`endif

endmodule

// File: tb/tb_hmem_responder.sv
// Directed bench for hmem_responder with default parameters (RD_LAT=40, AMO_LAT=8).
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at the same point.
// The invalidate check follows the HMEM_INV_EN setting of the build.
module tb_hmem_responder;
  import hmem_pkg::*;

  typedef logic [LINE_W-1:0] line_t;

  localparam line_t P11  = {(LINE_W/32){32'h1111_1111}};
  localparam line_t P22  = {(LINE_W/32){32'h2222_2222}};
  localparam line_t P33  = {(LINE_W/32){32'h3333_3333}};
  localparam line_t P44  = {(LINE_W/32){32'h4444_4444}};
  localparam line_t P55  = {(LINE_W/32){32'h5555_5555}};
  localparam line_t PDEAD = {(LINE_W/32){32'hDEAD_BEEF}};

  logic        h_clk = 1'b0;
  logic        h_rst;
  logic [63:0] h_addr;
  logic        h_rd;
  line_t       h_data_in;
  logic        h_dv;
  logic        h_wr;
  line_t       h_data_out;
  logic [63:0] h_inv_addr;
  logic        h_inv;
  logic        h_amo_req;
  logic        h_amo_ack;

  int checks = 0;
  int errors = 0;

  always #5 h_clk = ~h_clk;

  hmem_responder dut (
    .h_clk      (h_clk),
    .h_rst      (h_rst),
    .h_addr     (h_addr),
    .h_rd       (h_rd),
    .h_data_in  (h_data_in),
    .h_dv       (h_dv),
    .h_wr       (h_wr),
    .h_data_out (h_data_out),
    .h_inv_addr (h_inv_addr),
    .h_inv      (h_inv),
    .h_amo_req  (h_amo_req),
    .h_amo_ack  (h_amo_ack)
  );

  task automatic step();
    @(posedge h_clk);
    #1;
  endtask

  task automatic do_write(input logic [63:0] addr, input line_t dat);
    h_addr = addr; h_data_out = dat; h_wr = 1'b1;
    step();
    h_wr = 1'b0;
  endtask

  // Holds h_rd for n edges and records the h_dv pulses. Edge 1 is the edge that accepts the read.
  task automatic watch_read(input logic [63:0] addr, input int n, output int pulses,
                            output int first, output line_t dat, output int leaks);
    pulses = 0; first = -1; dat = '0; leaks = 0;
    h_addr = addr; h_rd = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (h_dv === 1'b1) begin
        pulses++;
        if (first < 0) begin first = k; dat = h_data_in; end
      end else if (h_data_in !== '0) begin
        leaks++;
      end
    end
    h_rd = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (h_dv !== 1'b0) begin errors++; $display("FAIL rst_dv got %b exp 0", h_dv); end
    checks++; if (h_data_in !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", h_data_in); end
    checks++; if (h_amo_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", h_amo_ack); end
    checks++; if (h_inv !== 1'b0) begin errors++; $display("FAIL rst_inv got %b exp 0", h_inv); end
    checks++; if (h_inv_addr !== 64'h0) begin errors++; $display("FAIL rst_inv_addr got %h exp 0", h_inv_addr); end
    h_rst = 1'b0;
    step();
  endtask

  task automatic test_read_latency();
    int p, f, lk; line_t d;
    do_write(64'h8000_0040, P11);
    watch_read(64'h8000_0040, 60, p, f, d, lk);
    checks++; if (p !== 1) begin errors++; $display("FAIL lat_pulses got %0d exp 1", p); end
    checks++; if (f !== 41) begin errors++; $display("FAIL lat_edge got %0d exp 41", f); end
    checks++; if (d !== P11) begin errors++; $display("FAIL lat_data got %h exp %h", d, P11); end
    checks++; if (lk !== 0) begin errors++; $display("FAIL lat_leak got %0d exp 0", lk); end
  endtask

  task automatic test_write_read();
    int p, f, lk; line_t d;
    do_write(64'h8000_0080, PDEAD);
    watch_read(64'h8000_0080, 45, p, f, d, lk);
    checks++; if (d !== PDEAD) begin errors++; $display("FAIL wr_rd got %h exp %h", d, PDEAD); end
    checks++; if (f !== 41) begin errors++; $display("FAIL wr_rd_edge got %0d exp 41", f); end
    watch_read(64'h8000_0088, 45, p, f, d, lk);
    checks++; if (d !== PDEAD) begin errors++; $display("FAIL low_bits got %h exp %h", d, PDEAD); end
    watch_read(64'h7FFF_FFC0, 45, p, f, d, lk);
    checks++; if (p !== 1) begin errors++; $display("FAIL below_pulses got %0d exp 1", p); end
    checks++; if (d !== '0) begin errors++; $display("FAIL below_data got %h exp 0", d); end
    do_write(64'h8000_0000, P22);
    do_write(64'h8001_0000, P33);
    watch_read(64'h8000_0000, 45, p, f, d, lk);
    checks++; if (d !== P22) begin errors++; $display("FAIL oor_alias got %h exp %h", d, P22); end
    watch_read(64'h8001_0000, 45, p, f, d, lk);
    checks++; if (d !== '0) begin errors++; $display("FAIL above_data got %h exp 0", d); end
  endtask

  task automatic test_abort();
    int p, f, lk, dv_seen; line_t d;
    dv_seen = 0;
    h_addr = 64'h8000_0040; h_rd = 1'b1;
    for (int k = 0; k < 10; k++) begin step(); if (h_dv !== 1'b0) dv_seen++; end
    h_rd = 1'b0;
    for (int k = 0; k < 50; k++) begin step(); if (h_dv !== 1'b0) dv_seen++; end
    checks++; if (dv_seen !== 0) begin errors++; $display("FAIL abort_dv got %0d exp 0", dv_seen); end
    watch_read(64'h8000_0040, 45, p, f, d, lk);
    checks++; if (f !== 41) begin errors++; $display("FAIL abort_rerd_edge got %0d exp 41", f); end
    checks++; if (d !== P11) begin errors++; $display("FAIL abort_rerd_data got %h exp %h", d, P11); end
  endtask

  task automatic test_write_during_read();
    int p, f, lk, pulses; line_t d;
    pulses = 0;
    do_write(64'h8000_00C0, P33);
    h_addr = 64'h8000_00C0; h_rd = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (h_dv === 1'b1) pulses++;
      if (k == 10) begin h_wr = 1'b1; h_data_out = P44; end
      if (k == 11) h_wr = 1'b0;
      if (k == 41) begin
        checks++; if (h_data_in !== P44) begin errors++; $display("FAIL wait_wr got %h exp %h", h_data_in, P44); end
        h_wr = 1'b1; h_data_out = P55;
        #1;
        checks++; if (h_data_in !== P55) begin errors++; $display("FAIL write_first got %h exp %h", h_data_in, P55); end
      end
      if (k == 42) h_wr = 1'b0;
    end
    h_rd = 1'b0;
    step();
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    watch_read(64'h8000_00C0, 45, p, f, d, lk);
    checks++; if (d !== P55) begin errors++; $display("FAIL wf_commit got %h exp %h", d, P55); end
  endtask

  task automatic test_amo();
    int p, f, lk, acks; line_t d;
    logic exp_ack;
    h_amo_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_ack = (k >= 8);
      checks++; if (h_amo_ack !== exp_ack) begin errors++; $display("FAIL amo_c%0d got %b exp %b", k, h_amo_ack, exp_ack); end
    end
    h_amo_req = 1'b0;
    step();
    checks++; if (h_amo_ack !== 1'b0) begin errors++; $display("FAIL amo_drop got %b exp 0", h_amo_ack); end
    acks = 0;
    h_amo_req = 1'b1;
    for (int k = 0; k < 3; k++) begin step(); if (h_amo_ack !== 1'b0) acks++; end
    h_amo_req = 1'b0;
    for (int k = 0; k < 10; k++) begin step(); if (h_amo_ack !== 1'b0) acks++; end
    checks++; if (acks !== 0) begin errors++; $display("FAIL amo_cancel got %0d exp 0", acks); end
    h_amo_req = 1'b1;
    for (int k = 0; k < 10; k++) step();
    watch_read(64'h8000_0040, 45, p, f, d, lk);
    checks++; if (d !== P11 || f !== 41) begin errors++; $display("FAIL amo_read got %h/%0d exp %h/41", d, f, P11); end
    checks++; if (h_amo_ack !== 1'b1) begin errors++; $display("FAIL amo_held got %b exp 1", h_amo_ack); end
    h_amo_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    int pulses, first; line_t d;
    h_addr = 64'h8000_0040; h_rd = 1'b1;
    for (int k = 0; k < 20; k++) step();
    h_rst = 1'b1;
    step(); step();
    h_rst = 1'b0;
    pulses = 0; first = -1; d = '0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (h_dv === 1'b1) begin pulses++; if (first < 0) begin first = k; d = h_data_in; end end
    end
    h_rd = 1'b0;
    step(); step();
    checks++; if (first !== 41 || pulses !== 1) begin errors++; $display("FAIL rst_mid got edge %0d pulses %0d exp 41/1", first, pulses); end
    checks++; if (d !== P11) begin errors++; $display("FAIL rst_keep_mem got %h exp %h", d, P11); end
    h_amo_req = 1'b1;
    h_rd = 1'b1;
    for (int k = 0; k < 41; k++) step();
    checks++; if (h_dv !== 1'b1 || h_amo_ack !== 1'b1) begin errors++; $display("FAIL pre_async got dv %b ack %b exp 1/1", h_dv, h_amo_ack); end
    #2;
    h_rst = 1'b1;
    #1;
    checks++; if (h_dv !== 1'b0) begin errors++; $display("FAIL async_dv got %b exp 0", h_dv); end
    checks++; if (h_data_in !== '0) begin errors++; $display("FAIL async_data got %h exp 0", h_data_in); end
    checks++; if (h_amo_ack !== 1'b0) begin errors++; $display("FAIL async_ack got %b exp 0", h_amo_ack); end
    h_rd = 1'b0; h_amo_req = 1'b0;
    step();
    h_rst = 1'b0;
    step();
  endtask

  task automatic test_inv();
    h_addr = 64'h8000_0088; h_data_out = P22; h_wr = 1'b1;
    step();
    h_wr = 1'b0;
`ifdef HMEM_INV_EN
    checks++; if (h_inv !== 1'b1) begin errors++; $display("FAIL inv_pulse got %b exp 1", h_inv); end
    checks++; if (h_inv_addr !== 64'h8000_0080) begin errors++; $display("FAIL inv_addr got %h exp 80000080", h_inv_addr); end
`else
    checks++; if (h_inv !== 1'b0) begin errors++; $display("FAIL inv_off got %b exp 0", h_inv); end
    checks++; if (h_inv_addr !== 64'h0) begin errors++; $display("FAIL inv_addr_off got %h exp 0", h_inv_addr); end
`endif
    step();
    checks++; if (h_inv !== 1'b0) begin errors++; $display("FAIL inv_one_cycle got %b exp 0", h_inv); end
    do_write(64'h7000_0000, P33);
    checks++; if (h_inv !== 1'b0) begin errors++; $display("FAIL inv_oor got %b exp 0", h_inv); end
  endtask

  initial begin
    h_rst = 1'b1; h_addr = '0; h_rd = 1'b0; h_wr = 1'b0; h_data_out = '0; h_amo_req = 1'b0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_abort();
    test_write_during_read();
    test_amo();
    test_reset_mid_read();
    test_inv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
